// File: rtl/seq_shifter_n.sv
// Serial shifter: shifts a WIDTH-bit operand one bit per clock by a run-time amount,
// using a start/in_ready request and an out_valid result pulse.
// Define SEQ_SHIFTER_STICKY_EN to add the sticky output (OR of bits shifted out on right shifts).
module seq_shifter_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       mode,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] X,
`ifdef SEQ_SHIFTER_STICKY_EN
  output logic             sticky,
`endif
  output logic             out_valid
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ModeLsl = 2'b00,
    ModeLsr = 2'b01,
    ModeAsr = 2'b10,
    ModeRor = 2'b11
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_step;
  logic             accept;

  always_comb begin
    x_step = x_q;
    unique case (mode_q)
      ModeLsl: x_step = {x_q[WIDTH-2:0], 1'b0};
      ModeLsr: x_step = {1'b0, x_q[WIDTH-1:1]};
      ModeAsr: x_step = {x_q[WIDTH-1], x_q[WIDTH-1:1]};
      ModeRor: x_step = {x_q[0], x_q[WIDTH-1:1]};
      default: x_step = x_q;
    endcase
  end

  assign in_ready  = (state_q == StIdle) || (state_q == StDone);
  assign busy      = (state_q == StShift);
  assign out_valid = (state_q == StDone);
  assign X         = x_q;
  assign accept    = start && in_ready;

`ifdef SEQ_SHIFTER_STICKY_EN
  logic sticky_q, sticky_d;
  logic right_step;

  assign right_step = (mode_q == ModeLsr) || (mode_q == ModeAsr);
  assign sticky     = sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (accept) begin
      sticky_d = 1'b0;
    end else if (state_q == StShift && right_step) begin
      sticky_d = sticky_q | x_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          x_d     = A;
          cnt_d   = amt;
          mode_d  = mode_e'(mode);
          state_d = (amt == '0) ? StDone : StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        x_d   = x_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= ModeLsl;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_seq_shifter_n.sv
// Self-checking bench for seq_shifter_n (WIDTH=8, SHW=3) with a result scoreboard.
// Honours SEQ_SHIFTER_STICKY_EN to also check the sticky output.
module tb_seq_shifter_n;

  localparam int unsigned W = 8;
  localparam int unsigned S = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [S-1:0] amt = '0;
  logic [1:0]   mode = '0;
  logic         in_ready, busy, out_valid;
  logic [W-1:0] x;
  logic         sticky_obs;

  typedef struct {
    logic [W-1:0] x;
    logic         st;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  seq_shifter_n #(.WIDTH(W), .SHW(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (a),
    .amt      (amt),
    .mode     (mode),
    .in_ready (in_ready),
    .busy     (busy),
    .X        (x),
`ifdef SEQ_SHIFTER_STICKY_EN
    .sticky   (sticky_obs),
`endif
    .out_valid(out_valid)
  );

`ifndef SEQ_SHIFTER_STICKY_EN
  assign sticky_obs = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference built from whole-word operators rather than per-step shifts.
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [S-1:0] n,
                                       input logic [1:0] m);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   r;
    logic [W-1:0]   lost;
    lost = av & ((W'(1) << n) - W'(1));
    dbl  = {av, av} >> n;
    unique case (m)
      2'b00:   return {1'b0, av << n};
      2'b01:   return {|lost, av >> n};
      2'b10:   begin r = W'($signed(av) >>> n); return {|lost, r}; end
      default: return {1'b0, dbl[W-1:0]};
    endcase
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("result_x", 32'(x), 32'(e.x));
        check_eq("latency", 32'(cyc), 32'(e.due));
        check_eq("busy_at_valid", 32'(busy), 32'd0);
`ifdef SEQ_SHIFTER_STICKY_EN
        check_eq("sticky", 32'(sticky_obs), 32'(e.st));
`endif
      end
    end
  end

  // Presents a request and holds start until accepted; start stays high on return.
  task automatic issue(input logic [W-1:0] av, input logic [S-1:0] n, input logic [1:0] m,
                       input logic [W-1:0] ex, input logic es);
    exp_t e;
    int   k;
    @(negedge clk);
    a = av; amt = n; mode = m; start = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      check_eq("busy_while_blocked", 32'(busy), 32'd1);
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      check_eq("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    @(posedge clk);
    #1;
    e.x = ex; e.st = es; e.due = cyc + int'(n);
    exp_q.push_back(e);
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    a = 8'hEE; amt = 3'd7; mode = 2'b11;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_const(input logic [W-1:0] av, input logic [S-1:0] n, input logic [1:0] m,
                           input logic [W-1:0] ex, input logic es);
    issue(av, n, m, ex, es);
    release_start();
    drain();
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra;
    logic [S-1:0] rn;
    logic [1:0]   rm;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_x", 32'(x), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_sticky", 32'(sticky_obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_const(8'hB0, 3'd3, 2'b10, 8'hF6, 1'b0);
    run_const(8'hFB, 3'd1, 2'b10, 8'hFD, 1'b1);
    run_const(8'h80, 3'd7, 2'b10, 8'hFF, 1'b0);
    run_const(8'h80, 3'd7, 2'b01, 8'h01, 1'b0);
    run_const(8'h81, 3'd1, 2'b00, 8'h02, 1'b0);
    run_const(8'h81, 3'd4, 2'b11, 8'h18, 1'b0);
    run_const(8'h08, 3'd3, 2'b01, 8'h01, 1'b0);
    run_const(8'h08, 3'd4, 2'b01, 8'h00, 1'b1);

    // amt=0: result the cycle after accept, never busy.
    for (int m = 0; m < 4; m++) begin
      issue(8'h5A, 3'd0, 2'(m), 8'h5A, 1'b0);
      check_eq("amt0_no_busy", 32'(busy), 32'd0);
      release_start();
      check_eq("amt0_done_no_busy", 32'(busy), 32'd0);
      drain();
    end

    // Start held with new operand during SHIFT, then accepted in the DONE cycle.
    issue(8'hC3, 3'd5, 2'b11, 8'h1E, 1'b0);
    issue(8'h0F, 3'd2, 2'b00, 8'h3C, 1'b0);
    release_start();
    drain();

    // Reset mid-shift abandons the operation.
    issue(8'h9C, 3'd6, 2'b10, 8'hFE, 1'b1);
    release_start();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_eq("midrst_x", 32'(x), 32'd0);
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_const(8'h9C, 3'd6, 2'b10, 8'hFE, 1'b1);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rn = S'($urandom_range(0, 7));
      rm = 2'($urandom_range(0, 3));
      r  = model(ra, rn, rm);
      issue(ra, rn, rm, r[W-1:0], r[W]);
      if ($urandom_range(0, 1) == 0) release_start();
    end
    release_start();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
